rom_alu_ram_engine: RTL and testbench
=====================================

Name: rom_alu_ram_engine

Overview:
Parametrised successor to the single-shot ROM-read, compute, RAM-write datapath. Reads two operands from an internal dual-read ROM, applies a selectable ALU op and writes the result to an internal RAM. Runs a start/busy/done FSM and supports batch mode with auto-incrementing, wrapping addresses. An independent RAM read port serves display and checking logic.

Parameters:
DATA_W, 8, operand/result/RAM word width (>=2)
ADDR_W, 3, address width; ROM and RAM depth = 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  00 add, 01 sub (A-B), 10 mul (low DATA_W bits), 11 pass A
adr1_rom  input  ADDR_W  first operand ROM address (A)
adr2_rom  input  ADDR_W  second operand ROM address (B)
adr_ram  input  ADDR_W  first RAM write address
len  input  ADDR_W  batch length minus 1 (0 = single op)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
result  output  DATA_W  last value written to RAM
ovf  output  1  sticky overflow/borrow for the current batch
rd_addr  input  ADDR_W  RAM read-port address
rd_data  output  DATA_W  RAM read data, registered

Behaviour:
- ROM contents are fixed: rom[i] = (3*i+1) mod 2**DATA_W. For the defaults: 1,4,7,10,13,16,19,22. ROM reads are synchronous (registered).
- RAM is not reset. Its contents are undefined until written.
- Reset (rst=0, asynchronous): FSM to IDLE; busy, done, result, ovf and rd_data go to 0; all internal address and count registers go to 0. A reset in mid-batch aborts it. RAM words already written keep their values.
- FSM states: IDLE, READ, EXEC, WRITE, DONE.
- IDLE: if start=1, latch op, adr1_rom, adr2_rom, adr_ram and len; clear ovf; go to READ.
- READ: the registered ROM outputs A and B become valid; go to EXEC.
- EXEC: compute into the result-stage register.
  - add: ovf event on carry out of bit DATA_W-1.
  - sub: ovf event on borrow (A<B).
  - mul: ovf event if any product bit at or above bit DATA_W is set.
  - pass: never raises ovf.
  - ovf |= event. Go to WRITE.
- WRITE: ram[wa] <= value; result <= value.
  - If count==0, go to DONE.
  - Otherwise: count--, adr1++, adr2++ and wa++, each modulo 2**ADDR_W (7 wraps to 0); go to READ.
- DONE: done=1 for this single cycle, then return to IDLE. A new start is accepted on the cycle after DONE at the earliest.
- Latency: if start is sampled at edge T0, done is high in the cycle after edge 3*(len+1). Single op: cycle 4.
- start is ignored while busy=1. Inputs other than start and rd_addr are don't-care after the latch.
- Read port: rd_data <= ram[rd_addr] on every clock, one-cycle latency, independent of the FSM. Reading and writing the same address on the same edge returns the old data.
- Width rules: all arithmetic is unsigned DATA_W. Results wrap modulo 2**DATA_W unless SAT_EN is defined.

Optional Feature:
Macro SAT_EN.
- Defined: arithmetic saturates.
  - add or mul overflow writes 2**DATA_W-1.
  - sub borrow writes 0.
  - ovf still flags the event.
- Undefined: results wrap modulo 2**DATA_W. No saturation logic is instantiated.

Test Plan:
1. Single add: op=00, adr1=1, adr2=2, adr_ram=0, len=0, start pulse -> ram[0]=11 via rd_addr=0; result=11; ovf=0; done high exactly in cycle 4; busy high cycles 1-3 and in the DONE cycle.
2. Sub with borrow: op=01, adr1=0, adr2=7, adr_ram=1 -> 1-22 wraps to 235 (0xEB); ovf=1. With SAT_EN: ram[1]=0, ovf=1.
3. Mul with overflow: op=10, adr1=7, adr2=7, adr_ram=2 -> 484 mod 256 = 228 (0xE4); ovf=1. With SAT_EN: 255.
4. Batch with wrap: op=00, adr1=6, adr2=7, adr_ram=6, len=2 -> ram[6]=41, ram[7]=23, ram[0]=5; result=5; done in cycle 10; ovf=0.
5. Start while busy: second start pulse during test 4 with different inputs -> ignored; outputs identical to test 4.
6. Reset mid-batch: assert rst=0 during the second element's EXEC of test 4 -> busy, done, result and ovf are 0 immediately, with no clock edge needed; ram[6]=41 remains; a new single op after release completes normally.

Source files
------------

// File: rtl/rom_alu_ram_engine.sv
// rom_alu_ram_engine: two ROM operands -> ALU -> RAM word, single op or wrapping batch.
// Latency: done pulses in the cycle after edge 3*(len+1) counted from the start edge; read port 1 cycle.
// Backpressure: none; start is ignored while busy, the RAM read port is always serviced.
//
// Ports: clk, rst (async, active-low)
//   start/op/adr1_rom/adr2_rom/adr_ram/len : command, latched only in IDLE
//   busy/done/result/ovf                    : status, all registered
//   rd_addr/rd_data                         : independent RAM read port, registered data
// Optional macro SAT_EN: saturate add/mul overflow to all-ones and sub borrow to zero.
module rom_alu_ram_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] adr1_rom,
  input  logic [ADDR_W-1:0] adr2_rom,
  input  logic [ADDR_W-1:0] adr_ram,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   adr1_q;
  logic [ADDR_W-1:0]   adr2_q;
  logic [ADDR_W-1:0]   wa_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   rom_a;
  logic [DATA_W-1:0]   rom_b;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   alu_val;
  logic                alu_evt;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W-1:0]   diff_w;
  logic [2*DATA_W-1:0] prod_w;
  logic [DATA_W-1:0]   mem [DEPTH];

  // ROM content is the fixed sequence 3*i+1, truncated to the word width.
  // ADDR_W+2 bits hold 3*i+1 for every address without overflow.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] i);
    logic [ADDR_W+1:0] t;
    t = {2'b00, i} + {1'b0, i, 1'b0} + (ADDR_W+2)'(1);
    return DATA_W'(t);
  endfunction

  // Registered ROM reads; addresses are stable during READ so data is valid in EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_a <= '0;
      rom_b <= '0;
    end else begin
      rom_a <= rom_word(adr1_q);
      rom_b <= rom_word(adr2_q);
    end
  end

  assign sum_w  = {1'b0, rom_a} + {1'b0, rom_b};
  assign diff_w = rom_a - rom_b;
  assign prod_w = {{DATA_W{1'b0}}, rom_a} * {{DATA_W{1'b0}}, rom_b};

  always_comb begin
    alu_val = rom_a;
    alu_evt = 1'b0;
    case (op_q)
      2'b00: begin
        alu_val = sum_w[DATA_W-1:0];
        alu_evt = sum_w[DATA_W];
      end
      2'b01: begin
        alu_val = diff_w;
        alu_evt = (rom_a < rom_b);
      end
      2'b10: begin
        alu_val = prod_w[DATA_W-1:0];
        alu_evt = |prod_w[2*DATA_W-1:DATA_W];
      end
      default: begin
        alu_val = rom_a;
        alu_evt = 1'b0;
      end
    endcase
`ifdef SAT_EN
    // Pass never raises an event, so only sub needs the low clamp.
    if (alu_evt) alu_val = (op_q == 2'b01) ? '0 : '1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      op_q   <= '0;
      adr1_q <= '0;
      adr2_q <= '0;
      wa_q   <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            adr1_q <= adr1_rom;
            adr2_q <= adr2_rom;
            wa_q   <= adr_ram;
            cnt_q  <= len;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            state  <= S_READ;
          end
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          res_q <= alu_val;
          ovf   <= ovf | alu_evt;
          state <= S_WRITE;
        end
        S_WRITE: begin
          result <= res_q;
          if (cnt_q == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            // Address arithmetic wraps naturally at ADDR_W bits.
            cnt_q  <= cnt_q - ADDR_W'(1);
            adr1_q <= adr1_q + ADDR_W'(1);
            adr2_q <= adr2_q + ADDR_W'(1);
            wa_q   <= wa_q + ADDR_W'(1);
            state  <= S_READ;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM storage is deliberately not reset so written words survive a reset.
  always_ff @(posedge clk) begin
    if (state == S_WRITE) mem[wa_q] <= res_q;
  end

  // Same-edge read of a word being written returns the previous contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_rom_alu_ram_engine.sv
`timescale 1ns/1ps
module tb_rom_alu_ram_engine;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int MAXV  = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [AW-1:0] adr1_rom = '0;
  logic [AW-1:0] adr2_rom = '0;
  logic [AW-1:0] adr_ram = '0;
  logic [AW-1:0] len = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [DW-1:0] result;
  logic [DW-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  rom_alu_ram_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .adr1_rom(adr1_rom), .adr2_rom(adr2_rom), .adr_ram(adr_ram), .len(len),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Reference state
  int ram_m [DEPTH];
  bit ram_k [DEPTH];
  int m_busy = 0, m_done = 0, m_res = 0, m_ovf = 0, m_rd = 0;
  bit m_rd_k = 1'b0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int rom_m(input int i);
    return (3 * (i % DEPTH) + 1) % MAXV;
  endfunction

  task automatic alu_m(input int o, input int a, input int b, output int val, output int ev);
    case (o)
      0:       begin val = a + b; ev = int'(val >= MAXV); end
      1:       begin val = a - b; ev = int'(a < b); end
      2:       begin val = a * b; ev = int'(val >= MAXV); end
      default: begin val = a;     ev = 0; end
    endcase
`ifdef SAT_EN
    if (ev != 0) val = (o == 1) ? 0 : MAXV - 1;
`endif
    val = ((val % MAXV) + MAXV) % MAXV;
  endtask

  // Behavioural model: on acceptance, precompute every element, then replay
  // the timeline (ovf at 3j+2, write at 3j+3, done at 3n, idle at 3n+1).
  initial begin : model
    int t, n, a, b, v, e;
    int vals [DEPTH];
    int evs  [DEPTH];
    int was  [DEPTH];
    bit active;
    t = 0; n = 0; active = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin ram_m[i] = 0; ram_k[i] = 1'b0; end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 0; m_done = 0; m_res = 0; m_ovf = 0; m_rd = 0; m_rd_k = 1'b1;
        active = 1'b0;
      end else begin
        m_rd   = ram_m[rd_addr];
        m_rd_k = ram_k[rd_addr];
        m_done = 0;
        if (active) begin
          t++;
          if (t % 3 == 2 && t / 3 < n && evs[t / 3] != 0) m_ovf = 1;
          if (t % 3 == 0 && t <= 3 * n) begin
            ram_m[was[t / 3 - 1]] = vals[t / 3 - 1];
            ram_k[was[t / 3 - 1]] = 1'b1;
            m_res = vals[t / 3 - 1];
          end
          if (t == 3 * n) m_done = 1;
          if (t == 3 * n + 1) begin m_busy = 0; active = 1'b0; end
        end else if (start) begin
          n = int'(len) + 1;
          for (int j = 0; j < n; j++) begin
            a = rom_m(int'(adr1_rom) + j);
            b = rom_m(int'(adr2_rom) + j);
            alu_m(int'(op), a, b, v, e);
            vals[j] = v;
            evs[j]  = e;
            was[j]  = (int'(adr_ram) + j) % DEPTH;
          end
          m_ovf = 0; m_busy = 1; active = 1'b1; t = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
      chk("result", int'(result), m_res);
      chk("ovf", int'(ovf), m_ovf);
      if (m_rd_k) chk("rd_data", int'(rd_data), m_rd);
    end
  end

  // mode 0: quiet, 1: random noise while busy, 2: one conflicting start in cycle 2
  task automatic run_op(input int o, input int a1, input int a2, input int ar, input int ln,
                        input int mode, input bit pin_busy, output int dcyc);
    int k;
    @(negedge clk);
    op = 2'(o); adr1_rom = AW'(a1); adr2_rom = AW'(a2); adr_ram = AW'(ar); len = AW'(ln);
    start = 1'b1;
    @(posedge clk);
    k = 0;
    dcyc = -1;
    while (k < 80) begin
      @(negedge clk);
      k++;
      if (pin_busy && k <= 3) chk("busy_early", int'(busy), 1);
      if (done) begin
        dcyc = k;
        start = 1'b0;
        break;
      end
      start = 1'b0;
      if (mode == 1) begin
        start    = 1'($urandom_range(0, 1));
        op       = 2'($urandom_range(0, 3));
        adr1_rom = AW'($urandom_range(0, DEPTH - 1));
        adr2_rom = AW'($urandom_range(0, DEPTH - 1));
        adr_ram  = AW'($urandom_range(0, DEPTH - 1));
        len      = AW'($urandom_range(0, DEPTH - 1));
        rd_addr  = AW'($urandom_range(0, DEPTH - 1));
      end else if (mode == 2 && k == 2) begin
        start = 1'b1; op = 2'b10; adr1_rom = 3'd7; adr2_rom = 3'd7; adr_ram = 3'd3; len = 3'd0;
      end
    end
    start = 1'b0;
    if (dcyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic rd_chk(input string nm, input int a, input int exp);
    @(negedge clk);
    rd_addr = AW'(a);
    @(negedge clk);
    chk(nm, int'(rd_data), exp);
  endtask

  initial begin : stim
    int d, ln;
    int exp_sub, exp_mul;
`ifdef SAT_EN
    exp_sub = 0;   exp_mul = 255;
`else
    exp_sub = 235; exp_mul = 228;
`endif
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst = 1'b1;
    checking = 1'b1;

    // single add: 4 + 7
    run_op(0, 1, 2, 0, 0, 0, 1'b1, d);
    chk("t1_done_cycle", d, 4);
    chk("t1_result", int'(result), 11);
    chk("t1_ovf", int'(ovf), 0);
    chk("t1_model_res", m_res, 11);
    rd_chk("t1_ram0", 0, 11);

    // sub with borrow: 1 - 22
    run_op(1, 0, 7, 1, 0, 0, 1'b0, d);
    chk("t2_result", int'(result), exp_sub);
    chk("t2_ovf", int'(ovf), 1);
    chk("t2_model_res", m_res, exp_sub);
    rd_chk("t2_ram1", 1, exp_sub);

    // mul with overflow: 22 * 22
    run_op(2, 7, 7, 2, 0, 0, 1'b0, d);
    chk("t3_result", int'(result), exp_mul);
    chk("t3_ovf", int'(ovf), 1);
    rd_chk("t3_ram2", 2, exp_mul);

    // batch with wrap, then same batch with a conflicting start
    for (int r = 0; r < 2; r++) begin
      run_op(0, 6, 7, 6, 2, (r == 0) ? 0 : 2, 1'b0, d);
      chk("t4_done_cycle", d, 10);
      chk("t4_result", int'(result), 5);
      chk("t4_ovf", int'(ovf), 0);
      rd_chk("t4_ram6", 6, 41);
      rd_chk("t4_ram7", 7, 23);
      rd_chk("t4_ram0", 0, 5);
    end

    // reset during the second element's EXEC
    @(negedge clk);
    op = 2'b00; adr1_rom = 3'd6; adr2_rom = 3'd7; adr_ram = 3'd6; len = 3'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pre_result", int'(result), 41);
    chk("t6_pre_busy", int'(busy), 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_result", int'(result), 0);
    chk("t6_ovf", int'(ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_chk("t6_ram6_kept", 6, 41);
    run_op(0, 3, 4, 3, 0, 0, 1'b0, d);
    chk("t6_new_done_cycle", d, 4);
    chk("t6_new_result", int'(result), 23);
    rd_chk("t6_ram3", 3, 23);

    // randomized batches with noisy inputs while busy
    for (int i = 0; i < 30; i++) begin
      ln = $urandom_range(0, DEPTH - 1);
      run_op($urandom_range(0, 3), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
             $urandom_range(0, DEPTH - 1), ln, 1, 1'b0, d);
      chk("rnd_done_cycle", d, 3 * (ln + 1) + 1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        rd_addr = AW'($urandom_range(0, DEPTH - 1));
      end
    end

    @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
